// File: rtl/tetris_pkg.sv
// Shared definitions for the playfield: command codes on the row-cell bus
// and the sequencer FSM state type.
package tetris_pkg;

  localparam logic [2:0] CMD_CHECK = 3'b000;
  localparam logic [2:0] CMD_MOVE  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_SHIFT = 3'b011;
  localparam logic [2:0] CMD_ADD   = 3'b100;

  typedef enum logic [3:0] {
    IDLE, ADD, ADD_CHK, FALL, MOVE, MOVE_CHK, WRITE, CHECK, SHIFT, OVER
  } seq_state_t;

  // Command driven to the row cells while the sequencer sits in state s.
  function automatic logic [2:0] cmd_of(input seq_state_t s);
    case (s)
      ADD:     return CMD_ADD;
      MOVE:    return CMD_MOVE;
      WRITE:   return CMD_WRITE;
      SHIFT:   return CMD_SHIFT;
      default: return CMD_CHECK;
    endcase
  endfunction

endpackage

// File: rtl/fall_timer.sv
// Gravity period timer: loadable down-counter that stops at zero.
// Ports: clk, reset (sync, active-low), load/load_val (reload), zero (count==0).
module fall_timer #(
  parameter int unsigned W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// Tetris playfield master controller: spawn, gravity fall, lock, line clear,
// game over. Drives the 3-bit command bus to the row cells.
// Ports: clk, reset (sync, active-low), start, drop, stop_in, endgame_in,
//        full_rows[ROWS] in; state[3], shift_row[ROW_W], lines[16],
//        game_over, busy out.
module game_sequencer
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS     = 20,
  parameter int unsigned FALL_DIV = 25000000,
  parameter int unsigned FAST_DIV = 2500000,
  parameter int unsigned ROW_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             drop,
  input  logic             stop_in,
  input  logic             endgame_in,
  input  logic [ROWS-1:0]  full_rows,
  output logic [2:0]       state,
  output logic [ROW_W-1:0] shift_row,
  output logic [15:0]      lines,
  output logic             game_over,
  output logic             busy
);

  localparam int unsigned TW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam int unsigned CW = $clog2(ROWS + 1);
  localparam logic [TW-1:0] FALL_LOAD = TW'(FALL_DIV - 1);
  localparam logic [TW-1:0] FAST_LOAD = TW'(FAST_DIV - 1);

  seq_state_t       st_q, st_d;
  logic [ROW_W-1:0] shift_row_q, shift_row_d;
  logic [15:0]      lines_q, lines_d;
  logic [CW-1:0]    shcnt_q, shcnt_d;
  logic             tmr_load, tmr_zero;
  logic [TW-1:0]    tmr_val;
  logic [ROW_W-1:0] low_idx;

  fall_timer #(.W(TW)) u_fall_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Lowest-index full row; scanning downward lets the lowest set bit win.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = ROWS; i > 0; i--) begin
      if (full_rows[i-1]) low_idx = ROW_W'(i - 1);
    end
  end

  always_comb begin
    st_d        = st_q;
    shift_row_d = shift_row_q;
    lines_d     = lines_q;
    shcnt_d     = shcnt_q;
    tmr_load    = 1'b0;
    tmr_val     = drop ? FAST_LOAD : FALL_LOAD;
    case (st_q)
      IDLE:     if (start) st_d = ADD;
      ADD:      st_d = ADD_CHK;
      ADD_CHK: begin
        if (endgame_in) st_d = OVER;
        else begin
          tmr_load = 1'b1;
          st_d     = FALL;
        end
      end
      // Timer is loaded with period-1, so FALL lasts exactly one period.
      FALL:     if (tmr_zero) st_d = MOVE;
      MOVE:     st_d = MOVE_CHK;
      MOVE_CHK: begin
        if (stop_in) st_d = WRITE;
        else begin
          tmr_load = 1'b1;
          st_d     = FALL;
        end
      end
      WRITE: begin
        shcnt_d = '0;
        st_d    = CHECK;
      end
      // Shift count bounds the clear loop if full_rows never drops.
      CHECK: begin
        if ((full_rows != '0) && (shcnt_q < CW'(ROWS))) begin
          shift_row_d = low_idx;
          st_d        = SHIFT;
        end else begin
          st_d = ADD;
        end
      end
      SHIFT: begin
        if (lines_q != '1) lines_d = lines_q + 16'd1;
        shcnt_d = shcnt_q + CW'(1);
        st_d    = CHECK;
      end
      OVER:     st_d = OVER;
      default:  st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q        <= IDLE;
      shift_row_q <= '0;
      lines_q     <= '0;
      shcnt_q     <= '0;
    end else begin
      st_q        <= st_d;
      shift_row_q <= shift_row_d;
      lines_q     <= lines_d;
      shcnt_q     <= shcnt_d;
    end
  end

  assign state     = cmd_of(st_q);
  assign shift_row = shift_row_q;
  assign lines     = lines_q;
  assign game_over = (st_q == OVER);
  assign busy      = (st_q != IDLE) && (st_q != OVER);

endmodule
